// File: rtl/ysyx_25010008_axi_rr_arbiter.sv
// N-master round-robin AXI4-Lite arbiter routing to io_master (external) or the read-only local CLINT slave.
// Optional watchdog with DRAIN recovery is enabled by defining ARB_TIMEOUT_EN.
module ysyx_25010008_axi_rr_arbiter #(
  parameter int          NUM_MASTERS    = 2,
  parameter logic [31:0] LOCAL_BASE     = 32'ha000_0048,
  parameter logic [31:0] LOCAL_MASK     = 32'hffff_fff8,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [32*NUM_MASTERS-1:0] m_araddr,
  input  logic [32*NUM_MASTERS-1:0] m_awaddr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
  input  logic [NUM_MASTERS-1:0]    m_arvalid,
  input  logic [NUM_MASTERS-1:0]    m_awvalid,
  input  logic [NUM_MASTERS-1:0]    m_wvalid,
  input  logic [NUM_MASTERS-1:0]    m_rready,
  input  logic [NUM_MASTERS-1:0]    m_bready,
  output logic [NUM_MASTERS-1:0]    m_arready,
  output logic [NUM_MASTERS-1:0]    m_awready,
  output logic [NUM_MASTERS-1:0]    m_wready,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic [NUM_MASTERS-1:0]    m_bvalid,
  output logic [32*NUM_MASTERS-1:0] m_rdata,
  output logic [2*NUM_MASTERS-1:0]  m_rresp,
  output logic [2*NUM_MASTERS-1:0]  m_bresp,
  input  logic                      io_master_awready,
  output logic                      io_master_awvalid,
  output logic [31:0]               io_master_awaddr,
  output logic [3:0]                io_master_awid,
  output logic [7:0]                io_master_awlen,
  output logic [2:0]                io_master_awsize,
  output logic [1:0]                io_master_awburst,
  input  logic                      io_master_wready,
  output logic                      io_master_wvalid,
  output logic [31:0]               io_master_wdata,
  output logic [3:0]                io_master_wstrb,
  output logic                      io_master_wlast,
  output logic                      io_master_bready,
  input  logic                      io_master_bvalid,
  input  logic [1:0]                io_master_bresp,
  input  logic                      io_master_arready,
  output logic                      io_master_arvalid,
  output logic [31:0]               io_master_araddr,
  output logic [3:0]                io_master_arid,
  output logic [7:0]                io_master_arlen,
  output logic [2:0]                io_master_arsize,
  output logic [1:0]                io_master_arburst,
  output logic                      io_master_rready,
  input  logic                      io_master_rvalid,
  input  logic [1:0]                io_master_rresp,
  input  logic [31:0]               io_master_rdata,
  output logic [31:0]               local_araddr,
  output logic                      local_arvalid,
  input  logic                      local_arready,
  input  logic [31:0]               local_rdata,
  input  logic [1:0]                local_rresp,
  input  logic                      local_rvalid,
  output logic                      local_rready
);

  // state   | meaning
  // S_IDLE  | no grant; round-robin pick among arvalid|awvalid requesters
  // S_READ  | granted master's AR/R wired to tgt slave
  // S_WRITE | granted master's AW/W/B wired to io_master
  // S_WERR  | write to local slave; arbiter absorbs AW/W and returns DECERR
  // S_DRAIN | watchdog fired; error to master, sink the late slave response
  localparam int N  = NUM_MASTERS;
  localparam int GW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("arbiter needs NUM_MASTERS >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_WERR
`ifdef ARB_TIMEOUT_EN
    , S_DRAIN
`endif
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant, last, win;
  logic            win_vld, tgt_local, aw_done, w_done;
  logic [N-1:0]    req;
  logic [31:0]     win_araddr, win_awaddr;
  logic            fire_r, fire_b;
  int              gi;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]     tmr;
  logic            rsp_pend, drain_rd, slv_done, slv_late;
`endif

  function automatic logic is_local(input logic [31:0] a);
    return (a & LOCAL_MASK) == LOCAL_BASE;
  endfunction

  assign req        = m_arvalid | m_awvalid;
  assign gi         = int'(grant);
  assign win_araddr = m_araddr[32*int'(win) +: 32];
  assign win_awaddr = m_awaddr[32*int'(win) +: 32];

  // first requester after the previous winner, wrapping modulo N
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!win_vld && req[(int'(last) + k) % N]) begin
        win_vld = 1'b1;
        win     = GW'((int'(last) + k) % N);
      end
    end
  end

  assign io_master_awlen   = 8'd0;
  assign io_master_arlen   = 8'd0;
  assign io_master_awsize  = 3'b010;
  assign io_master_arsize  = 3'b010;
  assign io_master_awburst = 2'b01;
  assign io_master_arburst = 2'b01;
  assign io_master_wlast   = io_master_wvalid;

  always_comb begin
    m_arready = '0; m_awready = '0; m_wready = '0; m_rvalid = '0; m_bvalid = '0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    io_master_awvalid = 1'b0; io_master_awaddr = '0; io_master_awid = '0;
    io_master_wvalid = 1'b0; io_master_wdata = '0; io_master_wstrb = '0;
    io_master_bready = 1'b0; io_master_arvalid = 1'b0; io_master_araddr = '0;
    io_master_arid = '0; io_master_rready = 1'b0;
    local_araddr = '0; local_arvalid = 1'b0; local_rready = 1'b0;
    case (state)
      S_READ: begin
        if (tgt_local) begin
          local_arvalid          = m_arvalid[gi];
          local_araddr           = m_araddr[32*gi +: 32];
          local_rready           = m_rready[gi];
          m_arready[gi]          = local_arready;
          m_rvalid[gi]           = local_rvalid;
          m_rdata[32*gi +: 32]   = local_rdata;
          m_rresp[2*gi +: 2]     = local_rresp;
        end else begin
          io_master_arvalid      = m_arvalid[gi];
          io_master_araddr       = m_araddr[32*gi +: 32];
          io_master_arid         = 4'(grant);
          io_master_rready       = m_rready[gi];
          m_arready[gi]          = io_master_arready;
          m_rvalid[gi]           = io_master_rvalid;
          m_rdata[32*gi +: 32]   = io_master_rdata;
          m_rresp[2*gi +: 2]     = io_master_rresp;
        end
      end
      S_WRITE: begin
        io_master_awvalid  = m_awvalid[gi];
        io_master_awaddr   = m_awaddr[32*gi +: 32];
        io_master_awid     = 4'(grant);
        io_master_wvalid   = m_wvalid[gi];
        io_master_wdata    = m_wdata[32*gi +: 32];
        io_master_wstrb    = m_wstrb[4*gi +: 4];
        io_master_bready   = m_bready[gi];
        m_awready[gi]      = io_master_awready;
        m_wready[gi]       = io_master_wready;
        m_bvalid[gi]       = io_master_bvalid;
        m_bresp[2*gi +: 2] = io_master_bresp;
      end
      S_WERR: begin
        m_awready[gi] = !aw_done;
        m_wready[gi]  = !w_done;
        m_bvalid[gi]  = aw_done && w_done;
        if (aw_done && w_done) m_bresp[2*gi +: 2] = 2'b11;
      end
`ifdef ARB_TIMEOUT_EN
      S_DRAIN: begin
        if (rsp_pend) begin
          if (drain_rd) begin
            m_rvalid[gi]       = 1'b1;
            m_rresp[2*gi +: 2] = 2'b10;
          end else begin
            m_bvalid[gi]       = 1'b1;
            m_bresp[2*gi +: 2] = 2'b10;
          end
        end
        if (!drain_rd)      io_master_bready = 1'b1;
        else if (tgt_local) local_rready     = 1'b1;
        else                io_master_rready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign fire_r = m_rvalid[gi] & m_rready[gi];
  assign fire_b = m_bvalid[gi] & m_bready[gi];

`ifdef ARB_TIMEOUT_EN
  assign slv_late = !drain_rd ? io_master_bvalid : (tgt_local ? local_rvalid : io_master_rvalid);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant     <= '0;
      last      <= GW'(N - 1);
      tgt_local <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmr       <= '0;
      rsp_pend  <= 1'b0;
      drain_rd  <= 1'b0;
      slv_done  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (win_vld) begin
          grant   <= win;
          last    <= win;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          tmr     <= 16'(TIMEOUT_CYCLES - 1);
`endif
          if (m_arvalid[win]) begin
            state     <= S_READ;
            tgt_local <= is_local(win_araddr);
          end else begin
            tgt_local <= 1'b0;
            state     <= is_local(win_awaddr) ? S_WERR : S_WRITE;
          end
        end
        S_READ, S_WRITE: begin
          if ((state == S_READ) ? fire_r : fire_b) state <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
          else if (tmr == '0) begin
            state    <= S_DRAIN;
            rsp_pend <= 1'b1;
            drain_rd <= (state == S_READ);
            slv_done <= 1'b0;
          end else tmr <= tmr - 16'd1;
`endif
        end
        S_WERR: begin
          aw_done <= aw_done | m_awvalid[gi];
          w_done  <= w_done | m_wvalid[gi];
          if (fire_b) state <= S_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        S_DRAIN: begin
          if (fire_r || fire_b) rsp_pend <= 1'b0;
          if (slv_late) slv_done <= 1'b1;
          if ((!rsp_pend || fire_r || fire_b) && (slv_done || slv_late)) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_axi_rr_arbiter.sv
// Directed bench for the round-robin arbiter: 2-master routing/WERR cases plus a 4-master fairness run.
// The watchdog section runs only when ARB_TIMEOUT_EN is defined.
module tb_ysyx_25010008_axi_rr_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // two-master instance
  logic [63:0] d_m_araddr, d_m_awaddr, d_m_wdata, d_m_rdata;
  logic [7:0]  d_m_wstrb;
  logic [1:0]  d_m_arvalid, d_m_awvalid, d_m_wvalid, d_m_rready, d_m_bready;
  logic [1:0]  d_m_arready, d_m_awready, d_m_wready, d_m_rvalid, d_m_bvalid;
  logic [3:0]  d_m_rresp, d_m_bresp;
  logic        d_io_awready, d_io_awvalid, d_io_wready, d_io_wvalid, d_io_wlast, d_io_bready, d_io_bvalid;
  logic        d_io_arready, d_io_arvalid, d_io_rready, d_io_rvalid;
  logic [31:0] d_io_awaddr, d_io_wdata, d_io_araddr, d_io_rdata;
  logic [3:0]  d_io_awid, d_io_arid, d_io_wstrb;
  logic [7:0]  d_io_awlen, d_io_arlen;
  logic [2:0]  d_io_awsize, d_io_arsize;
  logic [1:0]  d_io_awburst, d_io_arburst, d_io_bresp, d_io_rresp;
  logic [31:0] d_local_araddr, d_local_rdata;
  logic        d_local_arvalid, d_local_arready, d_local_rvalid, d_local_rready;
  logic [1:0]  d_local_rresp;

  ysyx_25010008_axi_rr_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(16)) u_dut2 (
    .clock(clock), .reset(reset),
    .m_araddr(d_m_araddr), .m_awaddr(d_m_awaddr), .m_wdata(d_m_wdata), .m_wstrb(d_m_wstrb),
    .m_arvalid(d_m_arvalid), .m_awvalid(d_m_awvalid), .m_wvalid(d_m_wvalid),
    .m_rready(d_m_rready), .m_bready(d_m_bready),
    .m_arready(d_m_arready), .m_awready(d_m_awready), .m_wready(d_m_wready),
    .m_rvalid(d_m_rvalid), .m_bvalid(d_m_bvalid),
    .m_rdata(d_m_rdata), .m_rresp(d_m_rresp), .m_bresp(d_m_bresp),
    .io_master_awready(d_io_awready), .io_master_awvalid(d_io_awvalid), .io_master_awaddr(d_io_awaddr),
    .io_master_awid(d_io_awid), .io_master_awlen(d_io_awlen), .io_master_awsize(d_io_awsize),
    .io_master_awburst(d_io_awburst), .io_master_wready(d_io_wready), .io_master_wvalid(d_io_wvalid),
    .io_master_wdata(d_io_wdata), .io_master_wstrb(d_io_wstrb), .io_master_wlast(d_io_wlast),
    .io_master_bready(d_io_bready), .io_master_bvalid(d_io_bvalid), .io_master_bresp(d_io_bresp),
    .io_master_arready(d_io_arready), .io_master_arvalid(d_io_arvalid), .io_master_araddr(d_io_araddr),
    .io_master_arid(d_io_arid), .io_master_arlen(d_io_arlen), .io_master_arsize(d_io_arsize),
    .io_master_arburst(d_io_arburst), .io_master_rready(d_io_rready), .io_master_rvalid(d_io_rvalid),
    .io_master_rresp(d_io_rresp), .io_master_rdata(d_io_rdata),
    .local_araddr(d_local_araddr), .local_arvalid(d_local_arvalid), .local_arready(d_local_arready),
    .local_rdata(d_local_rdata), .local_rresp(d_local_rresp), .local_rvalid(d_local_rvalid),
    .local_rready(d_local_rready)
  );

  // four-master instance for fairness
  logic [127:0] q_m_araddr, q_m_awaddr, q_m_wdata, q_m_rdata;
  logic [15:0]  q_m_wstrb;
  logic [3:0]   q_m_arvalid, q_m_awvalid, q_m_wvalid, q_m_rready, q_m_bready;
  logic [3:0]   q_m_arready, q_m_awready, q_m_wready, q_m_rvalid, q_m_bvalid;
  logic [7:0]   q_m_rresp, q_m_bresp;
  logic         q_io_awready, q_io_awvalid, q_io_wready, q_io_wvalid, q_io_wlast, q_io_bready, q_io_bvalid;
  logic         q_io_arready, q_io_arvalid, q_io_rready, q_io_rvalid;
  logic [31:0]  q_io_awaddr, q_io_wdata, q_io_araddr, q_io_rdata;
  logic [3:0]   q_io_awid, q_io_arid, q_io_wstrb;
  logic [7:0]   q_io_awlen, q_io_arlen;
  logic [2:0]   q_io_awsize, q_io_arsize;
  logic [1:0]   q_io_awburst, q_io_arburst, q_io_bresp, q_io_rresp;
  logic [31:0]  q_local_araddr, q_local_rdata;
  logic         q_local_arvalid, q_local_arready, q_local_rvalid, q_local_rready;
  logic [1:0]   q_local_rresp;

  ysyx_25010008_axi_rr_arbiter #(.NUM_MASTERS(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .m_araddr(q_m_araddr), .m_awaddr(q_m_awaddr), .m_wdata(q_m_wdata), .m_wstrb(q_m_wstrb),
    .m_arvalid(q_m_arvalid), .m_awvalid(q_m_awvalid), .m_wvalid(q_m_wvalid),
    .m_rready(q_m_rready), .m_bready(q_m_bready),
    .m_arready(q_m_arready), .m_awready(q_m_awready), .m_wready(q_m_wready),
    .m_rvalid(q_m_rvalid), .m_bvalid(q_m_bvalid),
    .m_rdata(q_m_rdata), .m_rresp(q_m_rresp), .m_bresp(q_m_bresp),
    .io_master_awready(q_io_awready), .io_master_awvalid(q_io_awvalid), .io_master_awaddr(q_io_awaddr),
    .io_master_awid(q_io_awid), .io_master_awlen(q_io_awlen), .io_master_awsize(q_io_awsize),
    .io_master_awburst(q_io_awburst), .io_master_wready(q_io_wready), .io_master_wvalid(q_io_wvalid),
    .io_master_wdata(q_io_wdata), .io_master_wstrb(q_io_wstrb), .io_master_wlast(q_io_wlast),
    .io_master_bready(q_io_bready), .io_master_bvalid(q_io_bvalid), .io_master_bresp(q_io_bresp),
    .io_master_arready(q_io_arready), .io_master_arvalid(q_io_arvalid), .io_master_araddr(q_io_araddr),
    .io_master_arid(q_io_arid), .io_master_arlen(q_io_arlen), .io_master_arsize(q_io_arsize),
    .io_master_arburst(q_io_arburst), .io_master_rready(q_io_rready), .io_master_rvalid(q_io_rvalid),
    .io_master_rresp(q_io_rresp), .io_master_rdata(q_io_rdata),
    .local_araddr(q_local_araddr), .local_arvalid(q_local_arvalid), .local_arready(q_local_arready),
    .local_rdata(q_local_rdata), .local_rresp(q_local_rresp), .local_rvalid(q_local_rvalid),
    .local_rready(q_local_rready)
  );

`ifdef ARB_TIMEOUT_EN
  // master 0 reads a hung external slave until the watchdog answers
  task automatic tout_read();
    int n = 0;
    d_m_araddr[31:0] = 32'h3000_0000;
    d_m_arvalid = 2'b01;
    d_m_rready  = 2'b00;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (d_m_rvalid[0]) break;
      if (d_io_arvalid) n++;
    end
    chk("to_cycles", n, 16);
    chk("to_rresp", d_m_rresp, 4'b0010);
    chk("to_isolated", d_io_arvalid, 0);
    chk("to_drain_rready", d_io_rready, 1);
    d_m_arvalid = 2'b00;
    d_m_rready  = 2'b01;
    tick();
    d_m_rready  = 2'b00;
    #1;
    chk("to_oneshot", d_m_rvalid, 2'b00);
  endtask
`endif

  initial begin
    d_m_araddr = '0; d_m_awaddr = '0; d_m_wdata = '0; d_m_wstrb = '0;
    d_m_arvalid = '0; d_m_awvalid = '0; d_m_wvalid = '0; d_m_rready = '0; d_m_bready = '0;
    d_io_awready = 0; d_io_wready = 0; d_io_bvalid = 0; d_io_bresp = '0;
    d_io_arready = 0; d_io_rvalid = 0; d_io_rresp = '0; d_io_rdata = '0;
    d_local_arready = 0; d_local_rdata = '0; d_local_rresp = '0; d_local_rvalid = 0;
    q_m_araddr = '0; q_m_awaddr = '0; q_m_wdata = '0; q_m_wstrb = '0;
    q_m_arvalid = '0; q_m_awvalid = '0; q_m_wvalid = '0; q_m_rready = '0; q_m_bready = '0;
    q_io_awready = 0; q_io_wready = 0; q_io_bvalid = 0; q_io_bresp = '0;
    q_io_arready = 0; q_io_rvalid = 0; q_io_rresp = '0; q_io_rdata = '0;
    q_local_arready = 0; q_local_rdata = '0; q_local_rresp = '0; q_local_rvalid = 0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_io_arvalid", d_io_arvalid, 0);
    chk("rst_io_awvalid", d_io_awvalid, 0);
    chk("rst_m_arready", d_m_arready, 0);
    chk("rst_local_arvalid", d_local_arvalid, 0);
    chk("rst_arsize", d_io_arsize, 3'b010);
    chk("rst_awburst", d_io_awburst, 2'b01);
    chk("rst_arlen", d_io_arlen, 0);
    reset = 1'b1;

    // simultaneous reads: master 0 then master 1
    d_m_araddr  = {32'h8000_0004, 32'h3000_0000};
    d_m_arvalid = 2'b11;
    d_m_rready  = 2'b11;
    #1;
    chk("idle_no_fwd", d_io_arvalid, 0);
    tick();
    chk("rd0_arvalid", d_io_arvalid, 1);
    chk("rd0_araddr", d_io_araddr, 32'h3000_0000);
    chk("rd0_arid", d_io_arid, 0);
    chk("rd0_local_quiet", d_local_arvalid, 0);
    d_io_arready = 1;
    #1;
    chk("rd0_arready", d_m_arready, 2'b01);
    tick();
    d_m_arvalid = 2'b10; d_io_arready = 0; d_io_rvalid = 1; d_io_rdata = 32'hdead_beef;
    #1;
    chk("rd0_rvalid", d_m_rvalid, 2'b01);
    chk("rd0_rdata", d_m_rdata, {32'h0, 32'hdead_beef});
    tick();
    d_io_rvalid = 0;
    #1;
    chk("rd_dead_cycle", d_io_arvalid, 0);
    tick();
    chk("rd1_araddr", d_io_araddr, 32'h8000_0004);
    chk("rd1_arid", d_io_arid, 1);
    d_io_arready = 1;
    tick();
    d_m_arvalid = 2'b00; d_io_arready = 0; d_io_rvalid = 1; d_io_rdata = 32'h5555_aaaa;
    #1;
    chk("rd1_rvalid", d_m_rvalid, 2'b10);
    chk("rd1_rdata", d_m_rdata, {32'h5555_aaaa, 32'h0});
    tick();
    d_io_rvalid = 0;

    // master 1 reads the local slave
    d_m_araddr[63:32] = 32'ha000_004c;
    d_m_arvalid = 2'b10;
    tick();
    chk("lrd_local_arvalid", d_local_arvalid, 1);
    chk("lrd_io_quiet", d_io_arvalid, 0);
    chk("lrd_local_araddr", d_local_araddr, 32'ha000_004c);
    d_local_arready = 1;
    tick();
    d_m_arvalid = 2'b00; d_local_arready = 0; d_local_rvalid = 1; d_local_rdata = 32'h1234;
    #1;
    chk("lrd_rdata1", d_m_rdata[63:32], 32'h1234);
    chk("lrd_rdata0", d_m_rdata[31:0], 0);
    chk("lrd_rvalid", d_m_rvalid, 2'b10);
    tick();
    d_local_rvalid = 0;

    // master 1 external write, W accepted before AW
    d_m_awaddr[63:32] = 32'h1000_0000;
    d_m_wdata[63:32]  = 32'hcafe_f00d;
    d_m_wstrb[7:4]    = 4'hf;
    d_m_awvalid = 2'b10; d_m_wvalid = 2'b10; d_m_bready = 2'b11;
    d_io_wready = 1;
    tick();
    chk("wr_io_wvalid", d_io_wvalid, 1);
    chk("wr_wready", d_m_wready, 2'b10);
    chk("wr_awready_wait", d_m_awready, 0);
    chk("wr_awaddr", d_io_awaddr, 32'h1000_0000);
    chk("wr_awid", d_io_awid, 1);
    chk("wr_wdata", d_io_wdata, 32'hcafe_f00d);
    chk("wr_wlast", d_io_wlast, 1);
    tick();
    d_m_wvalid = 2'b00; d_io_wready = 0; d_io_awready = 1;
    #1;
    chk("wr_awready", d_m_awready, 2'b10);
    chk("wr_w_done", d_io_wvalid, 0);
    tick();
    d_m_awvalid = 2'b00; d_io_awready = 0; d_io_bvalid = 1;
    d_m_arvalid = 2'b01; d_m_araddr[31:0] = 32'h3000_0010;
    #1;
    chk("wr_bvalid", d_m_bvalid, 2'b10);
    tick();
    d_io_bvalid = 0;
    #1;
    chk("wr_release_idle", d_io_arvalid, 0);
    tick();
    chk("wr_next_grant", d_io_arvalid, 1);
    chk("wr_next_araddr", d_io_araddr, 32'h3000_0010);
    d_io_arready = 1;
    tick();
    d_m_arvalid = 2'b00; d_io_arready = 0; d_io_rvalid = 1;
    tick();
    d_io_rvalid = 0;

    // master 0 writes the read-only local slave
    d_m_awaddr[31:0] = 32'ha000_0048;
    d_m_awvalid = 2'b01; d_m_wvalid = 2'b01; d_m_bready = 2'b00;
    d_io_awready = 1; d_io_wready = 1;
    tick();
    chk("werr_io_aw", d_io_awvalid, 0);
    chk("werr_io_w", d_io_wvalid, 0);
    chk("werr_awready", d_m_awready, 2'b01);
    chk("werr_wready", d_m_wready, 2'b01);
    chk("werr_bvalid_early", d_m_bvalid, 0);
    tick();
    d_m_awvalid = 2'b00; d_m_wvalid = 2'b00;
    #1;
    chk("werr_bvalid", d_m_bvalid, 2'b01);
    chk("werr_bresp", d_m_bresp, 4'b0011);
    chk("werr_aw_closed", d_m_awready, 0);
    tick();
    chk("werr_bvalid_hold", d_m_bvalid, 2'b01);
    d_m_bready = 2'b01;
    tick();
    d_m_bready = 2'b00; d_io_awready = 0; d_io_wready = 0;
    #1;
    chk("werr_release", d_m_bvalid, 0);

    // four masters requesting continuously
    q_m_araddr  = {32'h4000_000c, 32'h4000_0008, 32'h4000_0004, 32'h4000_0000};
    q_m_arvalid = 4'hf; q_m_rready = 4'hf; q_io_arready = 1; q_io_rvalid = 1;
    begin
      int n = 0;
      for (int c = 0; c < 100 && n < 8; c++) begin
        tick();
        if (q_io_arvalid) begin
          chk($sformatf("rr_grant%0d", n), q_io_arid, n % 4);
          n++;
        end
      end
      chk("rr_count", n, 8);
    end
    q_m_arvalid = '0; q_io_arready = 0; q_io_rvalid = 0;

`ifdef ARB_TIMEOUT_EN
    tout_read();
    repeat (3) tick();
    chk("drain_hold", d_io_rready, 1);
    d_io_rvalid = 1;
    tick();
    d_io_rvalid = 0;
    #1;
    chk("drain_exit", d_io_rready, 0);
    chk("drain_discard", d_m_rvalid, 0);
    tout_read();
    reset = 1'b0;
    #1;
    chk("rst_mid_drain_rready", d_io_rready, 0);
    chk("rst_mid_drain_rvalid", d_m_rvalid, 0);
    reset = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
